// File: rtl/uart_rx.sv
// uart_rx: 8E1 serial receiver, 2-flop input synchronizer, mid-bit sampling.
// Latency: line fall to rx_valid = 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles.
// No backpressure: each completed frame overwrites data_out and the error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_reg_q, shift_reg_d;
  logic        par_bit_q, par_bit_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  // Next-state logic: synchronizer, bit timing, frame decode and registered outputs.
  always_comb begin
    rx_meta_d    = rx_in;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_reg_d  = shift_reg_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          baud_cnt_d = 16'd0;
          state_d    = START;
        end
      end
      START: begin
        // Re-check the line at half a bit to reject glitches.
        if (baud_cnt_q == HALF_M1) begin
          if (!rx_s_q) begin
            baud_cnt_d = 16'd0;
            bit_idx_d  = 3'd0;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d  = 16'd0;
          shift_reg_d = {rx_s_q, shift_reg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = 16'd0;
          par_bit_d  = rx_s_q;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d   = 16'd0;
          data_out_d   = shift_reg_q;
          parity_err_d = par_bit_q ^ (^shift_reg_q);
          frame_err_d  = ~rx_s_q;
          rx_valid_d   = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          state_d      = rx_s_q ? IDLE : WAIT_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      baud_cnt_q   <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_reg_q  <= 8'h00;
      par_bit_q    <= 1'b0;
      data_out_q   <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_reg_q  <= shift_reg_d;
      par_bit_q    <= par_bit_d;
      data_out_q   <= data_out_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, expected {frame_err, parity_err, data}
// pushed to a scoreboard when sent and compared on each rx_valid pulse.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_valid_cyc = -1;
  int fall_cyc = 0;
  int pulses_before = 0;
  logic [9:0] sb_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Pop and compare one scoreboard entry per rx_valid pulse.
  always @(negedge clock) begin
    logic [9:0] exp;
    logic       have;
    if (rx_valid === 1'b1) begin
      pulses++;
      last_valid_cyc = cyc;
      have = (sb_q.size() != 0);
      checks++;
      assert (have === 1'b1) else begin
        errors++;
        $error("FAIL unexpected_pulse observed data=%h expected no pulse", data_out);
      end
      if (have) begin
        exp = sb_q.pop_front();
        checks++;
        assert (data_out === exp[7:0]) else begin
          errors++;
          $error("FAIL data_out observed %h expected %h", data_out, exp[7:0]);
        end
        checks++;
        assert (parity_err === exp[8]) else begin
          errors++;
          $error("FAIL parity_err data=%h observed %b expected %b", exp[7:0], parity_err, exp[8]);
        end
        checks++;
        assert (frame_err === exp[9]) else begin
          errors++;
          $error("FAIL frame_err data=%h observed %b expected %b", exp[7:0], frame_err, exp[9]);
        end
      end
    end
  end

  // Hold one line level for a full bit period; always returns at posedge+1.
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * CPB) @(posedge clock);
    #1;
  endtask

  // Push the expected result, then serialise start, data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    sb_q.push_back({~stop, par ^ (^d), d});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (data_out === 8'h00) else begin
      errors++;
      $error("FAIL %s data_out observed %h expected 00", tag, data_out);
    end
    checks++;
    assert (rx_valid === 1'b0) else begin
      errors++;
      $error("FAIL %s rx_valid observed %b expected 0", tag, rx_valid);
    end
    checks++;
    assert (parity_err === 1'b0) else begin
      errors++;
      $error("FAIL %s parity_err observed %b expected 0", tag, parity_err);
    end
    checks++;
    assert (frame_err === 1'b0) else begin
      errors++;
      $error("FAIL %s frame_err observed %b expected 0", tag, frame_err);
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL %s busy observed %b expected 0", tag, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_bits(1);

    // Valid frame and its latency from the line falling edge.
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);
    checks++;
    assert ((last_valid_cyc - fall_cyc) === 171) else begin
      errors++;
      $error("FAIL latency observed %0d expected 171", last_valid_cyc - fall_cyc);
    end

    // Parity error, then a correct odd-weight byte clears the flag.
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_bits(2);
    send_frame(8'h01, 1'b1, 1'b1);
    idle_bits(2);

    // Framing error followed by a long break: one pulse only.
    pulses_before = pulses;
    send_frame(8'h81, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (30 * CPB) @(posedge clock);
    #1;
    idle_bits(3);
    checks++;
    assert ((pulses - pulses_before) === 1) else begin
      errors++;
      $error("FAIL break_pulses observed %0d expected 1", pulses - pulses_before);
    end
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(2);

    // Glitch shorter than half a bit is rejected after the start check.
    pulses_before = pulses;
    rx_in = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    assert (busy === 1'b1) else begin
      errors++;
      $error("FAIL glitch_busy_high observed %b expected 1", busy);
    end
    repeat (2) @(posedge clock);
    #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL glitch_busy_low observed %b expected 0", busy);
    end
    checks++;
    assert ((pulses - pulses_before) === 0) else begin
      errors++;
      $error("FAIL glitch_pulses observed %0d expected 0", pulses - pulses_before);
    end
    @(posedge clock);
    #1;
    idle_bits(1);

    // Back-to-back frames with no idle between stop and next start.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle_bits(2);

    // Reset asserted during data bit 4 of 0x96 aborts the frame.
    pulses_before = pulses;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h96 >> i));
    rx_in = 1'(8'h96 >> 4);
    repeat (CPB / 2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    rx_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle_bits(2);
    checks++;
    assert ((pulses - pulses_before) === 0) else begin
      errors++;
      $error("FAIL aborted_frame_pulses observed %0d expected 0", pulses - pulses_before);
    end
    send_frame(8'h96, 1'b0, 1'b1);
    idle_bits(2);

    // Drain: every sent frame must have produced its pulse.
    for (int i = 0; i < 1000 && sb_q.size() != 0; i++) @(posedge clock);
    checks++;
    assert (sb_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d pending expected 0", sb_q.size());
    end
    checks++;
    assert (pulses === 9) else begin
      errors++;
      $error("FAIL total_pulses observed %0d expected 9", pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the team's UART link. It accepts the frame the transmit datapath drives on `tx_out`: one start bit (0), 8 data bits LSB first, one even-parity bit (XOR of the data bits), and one stop bit (1). It samples each bit at its midpoint and returns the byte with parity and framing status. It sits between the serial line and the host-side byte interface.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; valid range 4..65535.
- `clock`  input  1  system clock; every flop updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `rx_in`  input  1  serial line, asynchronous to `clock`; idles high.
- `data_out`  output  8  last received byte; holds until the next frame completes.
- `rx_valid`  output  1  one-cycle pulse when a frame completes.
- `parity_err`  output  1  parity bit of the last frame ≠ XOR of its data; changes only at the `rx_valid` pulse.
- `frame_err`  output  1  stop bit of the last frame sampled 0; changes only at the `rx_valid` pulse.
- `busy`  output  1  high in every state except IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer (`rx_s`), which adds 2 cycles of line latency. `rx_s` resets to 1.
- Internal registers:
  - Bit-timer `baud_cnt`: 16 bits, counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - `bit_idx`: 3 bits.
  - `shift_reg`: 8 bits; LSB-first receive, so each sample enters at bit 7 and shifts right.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - **IDLE:** on `rx_s`=0, clear `baud_cnt` and go to START.
  - **START:** when `baud_cnt` = CLKS_PER_BIT/2 - 1 (integer division), sample `rx_s`.
    - If 0: clear `baud_cnt`, clear `bit_idx`, go to DATA.
    - If 1: false start; go to IDLE with no output change.
  - **DATA:** when `baud_cnt` = CLKS_PER_BIT-1, shift `rx_s` into `shift_reg` and clear `baud_cnt`.
    - After the sample taken at `bit_idx`=7, go to PARITY.
    - Otherwise increment `bit_idx`.
  - **PARITY:** when `baud_cnt` = CLKS_PER_BIT-1, latch the sampled bit as `par_bit` and go to STOP.
  - **STOP:** when `baud_cnt` = CLKS_PER_BIT-1, sample the stop bit, then in the same cycle:
    - load `data_out` ← `shift_reg`;
    - set `parity_err` ← `par_bit` XOR (^`shift_reg`);
    - set `frame_err` ← ~`rx_s`;
    - pulse `rx_valid`.
    - Next state: IDLE if the stop bit is 1, else WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. A held-low line (break) therefore produces exactly one frame, and that frame has `frame_err`=1.
- Data is delivered even on error; the consumer qualifies it with `parity_err` and `frame_err`.
- No backpressure. A new `rx_valid` overwrites the previous `data_out` and error flags.

## Timing
- Reset values:
  - `data_out`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - FSM=IDLE; all counters 0.
- Reset asserted mid-frame aborts the frame immediately. No `rx_valid` is issued for the aborted frame.
- Reception after reset release:
  - With the line high at release, reception begins at the next falling edge.
  - With the line low at release, the FSM takes it as a start bit. It is then either accepted (line still low at the half-bit check) or rejected as a false start.
- Sample points, counted from the cycle `rx_s` first reads 0:
  - start check at +CLKS_PER_BIT/2;
  - data bit k at +CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - parity at +CLKS_PER_BIT/2 + 9·CLKS_PER_BIT;
  - stop at +CLKS_PER_BIT/2 + 10·CLKS_PER_BIT.
- `rx_valid` is registered. It is high in the cycle after the stop-sample edge, for exactly one cycle. `data_out`, `parity_err` and `frame_err` are valid in that same cycle.
- Latency from the line falling edge to `rx_valid` = 2 (sync) + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT + 1 cycles. For CLKS_PER_BIT=16 this is 171 cycles.
- Back-to-back frames: a start edge that arrives in the cycle the FSM returns to IDLE is detected in that cycle. This gives ~CLKS_PER_BIT/2 of margin before the next start bit.
- `busy` is registered from the FSM state. It rises 1 cycle after start detection and falls when the FSM enters IDLE.

## Test plan
- **Valid frame:** CLKS_PER_BIT=16, send 0xA5 with parity 0 and stop 1.
  - Required: one `rx_valid` pulse; `data_out`=0xA5; `parity_err`=0; `frame_err`=0.
  - Check that the pulse lands 171 cycles after the line falling edge.
- **Parity error:** send 0x3C with parity bit 1 (correct value is 0).
  - Required: `data_out`=0x3C, `parity_err`=1, `frame_err`=0.
  - Then send 0x01 with parity 1 (correct). Required: `parity_err` returns to 0.
- **Framing error / break:** send 0x81 with stop bit 0, then hold the line low for 30 bit times.
  - Required: exactly one `rx_valid`, with `frame_err`=1 and `data_out`=0x81.
  - After the line returns high, a 0x55 frame is received clean.
- **Glitch rejection:** drive the line low for 6 cycles (< CLKS_PER_BIT/2).
  - Required: no `rx_valid`; `busy` returns to 0; the FSM is back in IDLE.
- **Back-to-back frames:** send 0x00, 0xFF and 0x7E with zero idle between stop and start.
  - Required: three pulses carrying 0x00, 0xFF, 0x7E, all with both error flags 0.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0x96.
  - Required: all outputs at reset values immediately and no pulse for 0x96.
  - After release and line idle, 0x96 resent is received correctly.
